// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings for the data-memory access stage
package mem_pkg;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  localparam funct3_e F3_SB = F3_LB;
  localparam funct3_e F3_SH = F3_LH;
  localparam funct3_e F3_SW = F3_LW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unused encodings (011, 110, 111) fall through to word accesses.
  function automatic size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - load data lane extraction and sign/zero extension
module load_align #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] raw,
  input  logic [1:0]       off,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data
);
  import mem_pkg::*;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = raw >> {off, 3'b000};
    data    = raw;
    case (access_size(funct3))
      SZ_BYTE: data = funct3[2] ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = funct3[2] ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: dmem req/ack handshake, lanes, load alignment (option: MEM_MISALIGN_TRAP_EN)
module mem_access_stage #(
  parameter int WIDTH = 32,
  parameter int BE_W  = mem_pkg::BE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             misalign_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [WIDTH-1:0] dmem_addr_o,
  output logic [WIDTH-1:0] dmem_wdata_o,
  output logic [BE_W-1:0]  dmem_be_o,
  input  logic             dmem_ack_i,
  input  logic [WIDTH-1:0] dmem_rdata_i
);
  import mem_pkg::*;

  state_e           state, state_nxt;
  size_e            size;
  logic             access, misalign, issue;
  logic [1:0]       off;
  logic [BE_W-1:0]  be_nxt;
  logic [WIDTH-1:0] wdata_lanes, load_data;
  logic             ld_pend;
  logic [1:0]       ld_off;
  logic [2:0]       ld_f3;

  always_comb begin
    size        = access_size(funct3_i);
    access      = valid_i & (mem_read_i | mem_write_i);
    off         = 2'b00;
    be_nxt      = 4'b1111;
    wdata_lanes = wdata_i;
    // Offending low address bits are dropped here, so a word always uses offset 0.
    case (size)
      SZ_BYTE: begin
        off         = addr_i[1:0];
        be_nxt      = 4'b0001 << addr_i[1:0];
        wdata_lanes = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        off         = {addr_i[1], 1'b0};
        be_nxt      = 4'b0011 << {addr_i[1], 1'b0};
        wdata_lanes = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = access & (((size == SZ_HALF) & addr_i[0]) |
                         ((size == SZ_WORD) & (addr_i[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
    issue      = (state == S_IDLE) & access & ~misalign;
    misalign_o = ~rst & (state == S_IDLE) & misalign;
    stall_o    = ~rst & (issue | (state == S_WAIT));

    state_nxt = state;
    case (state)
      S_IDLE:  if (issue) state_nxt = S_WAIT;
      S_WAIT:  if (dmem_ack_i) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .raw    (dmem_rdata_i),
    .off    (ld_off),
    .funct3 (ld_f3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      rdata_o      <= '0;
      ld_pend      <= 1'b0;
      ld_off       <= 2'b00;
      ld_f3        <= 3'b000;
    end else if (issue) begin
      dmem_req_o   <= 1'b1;
      dmem_we_o    <= mem_write_i;
      dmem_addr_o  <= {addr_i[WIDTH-1:2], 2'b00};
      dmem_wdata_o <= mem_write_i ? wdata_lanes : '0;
      dmem_be_o    <= be_nxt;
      ld_pend      <= ~mem_write_i;
      ld_off       <= off;
      ld_f3        <= funct3_i;
    end else if ((state == S_WAIT) && dmem_ack_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      if (ld_pend) rdata_o <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - vector table, corner sequences and random model check for mem_access_stage (honours MEM_MISALIGN_TRAP_EN)
module tb_mem_access_stage;

  logic        clk, rst, valid_i, mem_read_i, mem_write_i, dmem_ack_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, dmem_rdata_i;
  logic        stall_o, misalign_o, dmem_req_o, dmem_we_o;
  logic [31:0] rdata_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        valid, rd, wr;
    bit [2:0]  f3;
    bit [31:0] addr, wdata, raw;
    int        dly;
    int        exp_stall;
    bit [31:0] exp_addr;
    bit [3:0]  exp_be;
    bit [31:0] exp_wdata;
    bit        exp_we;
    bit [31:0] exp_rdata;
    bit        exp_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit valid, bit rd, bit wr, bit [2:0] f3, bit [31:0] addr,
                              bit [31:0] wdata, bit [31:0] raw, int dly, int exp_stall,
                              bit [31:0] exp_addr, bit [3:0] exp_be, bit [31:0] exp_wdata,
                              bit exp_we, bit [31:0] exp_rdata, bit exp_mis);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.raw = raw; v.dly = dly; v.exp_stall = exp_stall; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_we = exp_we;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Reference model: access size in bytes and plain arithmetic on byte offsets.
  function automatic int nbytes(bit [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_mis(bit [2:0] f3, bit [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (nbytes(f3) == 2 && addr % 2 != 0) || (nbytes(f3) == 4 && addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_off(bit [2:0] f3, bit [31:0] addr);
    int n = nbytes(f3);
    if (n == 4) return 0;
    if (n == 2) return ((addr % 4) / 2) * 2;
    return int'(addr % 4);
  endfunction

  function automatic bit [3:0] ref_be(bit [2:0] f3, bit [31:0] addr);
    int n = nbytes(f3);
    if (n == 4) return 4'hF;
    return 4'((2 ** n - 1) * (2 ** ref_off(f3, addr)));
  endfunction

  function automatic bit [31:0] ref_wdata(bit [2:0] f3, bit [31:0] wdata);
    int n = nbytes(f3);
    if (n == 1) return (wdata % 256) * 32'h0101_0101;
    if (n == 2) return (wdata % 65536) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic bit [31:0] ref_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] raw);
    int        n = nbytes(f3);
    bit [31:0] lim, val;
    if (n == 4) return raw;
    lim = 32'(2 ** (8 * n));
    val = (raw / 32'(2 ** (8 * ref_off(f3, addr)))) % lim;
    if ((f3 == 3'd0 || f3 == 3'd1) && val >= lim / 2) val = val - lim;
    return val;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int stalls = 0;
    valid_i = v.valid; mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3;
    addr_i = v.addr; wdata_i = v.wdata; dmem_rdata_i = v.raw; dmem_ack_i = 1'b0;
    @(negedge clk);
    chk({tag, " misalign"}, misalign_o, v.exp_mis);
    chk({tag, " idle_req"}, dmem_req_o, 0);
    if (v.exp_stall == 0) begin
      chk({tag, " nostall"}, stall_o, 0);
      chk({tag, " rdata_hold"}, rdata_o, v.exp_rdata);
      @(posedge clk); #1;
    end else begin
      stalls += int'(stall_o);
      @(posedge clk); #1;
      for (int w = 0; w <= v.dly; w++) begin
        dmem_ack_i = (w == v.dly);
        @(negedge clk);
        stalls += int'(stall_o);
        chk({tag, " req"}, dmem_req_o, 1);
        chk({tag, " we"}, dmem_we_o, v.exp_we);
        chk({tag, " addr"}, dmem_addr_o, v.exp_addr);
        chk({tag, " be"}, dmem_be_o, v.exp_be);
        chk({tag, " wdata"}, dmem_wdata_o, v.exp_wdata);
        @(posedge clk); #1;
      end
      dmem_ack_i = 1'b0;
      @(negedge clk);
      stalls += int'(stall_o);
      chk({tag, " resp_req"}, dmem_req_o, 0);
      chk({tag, " rdata"}, rdata_o, v.exp_rdata);
      @(posedge clk); #1;
      chk({tag, " stall_cycles"}, stalls, v.exp_stall);
    end
  endtask

  vec_t      tbl[$];
  vec_t      v;
  bit [31:0] last_rd;
  bit        acc;

  initial begin
    tbl.push_back(mk(1,1,0,3'd2,32'h100,0,32'hDEADBEEF,0,2,32'h100,4'hF,0,0,32'hDEADBEEF,0));
    tbl.push_back(mk(1,1,0,3'd0,32'h103,0,32'h80FF0000,0,2,32'h100,4'h8,0,0,32'hFFFFFF80,0));
    tbl.push_back(mk(1,1,0,3'd4,32'h103,0,32'h80FF0000,0,2,32'h100,4'h8,0,0,32'h00000080,0));
    tbl.push_back(mk(1,0,1,3'd1,32'h202,32'h1234ABCD,0,2,4,32'h200,4'hC,32'hABCDABCD,1,32'h80,0));
    tbl.push_back(mk(1,0,0,3'd0,32'h55,0,0,0,0,0,0,0,0,32'h80,0));
    tbl.push_back(mk(1,1,0,3'd2,32'h100,0,32'h11223344,0,2,32'h100,4'hF,0,0,32'h11223344,0));
    tbl.push_back(mk(1,1,0,3'd1,32'h102,0,32'h80017777,0,2,32'h100,4'hC,0,0,32'hFFFF8001,0));
    tbl.push_back(mk(1,1,0,3'd5,32'h100,0,32'h80017777,0,2,32'h100,4'h3,0,0,32'h00007777,0));
    tbl.push_back(mk(1,0,1,3'd0,32'h301,32'h123456A5,0,1,3,32'h300,4'h2,32'hA5A5A5A5,1,32'h7777,0));
    tbl.push_back(mk(1,0,1,3'd2,32'h40,32'hCAFEF00D,0,0,2,32'h40,4'hF,32'hCAFEF00D,1,32'h7777,0));
    tbl.push_back(mk(1,1,0,3'd7,32'h44,0,32'h12345678,0,2,32'h44,4'hF,0,0,32'h12345678,0));
    tbl.push_back(mk(0,1,0,3'd2,32'h44,0,32'hFFFFFFFF,0,0,0,0,0,0,32'h12345678,0));
    tbl.push_back(mk(1,1,1,3'd2,32'h48,32'h0BADF00D,32'hFFFFFFFF,0,2,32'h48,4'hF,32'h0BADF00D,1,32'h12345678,0));
    tbl.push_back(mk(1,1,0,3'd3,32'h4C,0,32'hA0B0C0D0,0,2,32'h4C,4'hF,0,0,32'hA0B0C0D0,0));

    rst = 1'b1; valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
    addr_i = 0; wdata_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", stall_o, 0);
    chk("reset req", dmem_req_o, 0);
    chk("reset we", dmem_we_o, 0);
    chk("reset addr", dmem_addr_o, 0);
    chk("reset be", dmem_be_o, 0);
    chk("reset wdata", dmem_wdata_o, 0);
    chk("reset rdata", rdata_o, 0);
    chk("reset misalign", misalign_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while an access is outstanding, then a late ack that must be dropped.
    valid_i = 1; mem_read_i = 1; mem_write_i = 0; funct3_i = 3'd2; addr_i = 32'h10;
    dmem_rdata_i = 32'hAAAA5555; dmem_ack_i = 0;
    @(negedge clk); chk("midrst issue_stall", stall_o, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("midrst wait_req", dmem_req_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 0; mem_read_i = 0; dmem_ack_i = 1;
    @(negedge clk);
    chk("midrst req", dmem_req_o, 0);
    chk("midrst stall", stall_o, 0);
    chk("midrst rdata", rdata_o, 0);
    chk("midrst be", dmem_be_o, 0);
    @(posedge clk); #1;
    dmem_ack_i = 0;
    @(negedge clk);
    chk("late_ack rdata", rdata_o, 0);
    chk("late_ack req", dmem_req_o, 0);
    @(posedge clk); #1;
    run_op(mk(1,1,0,3'd2,32'h20,0,32'h0F0F0F0F,1,3,32'h20,4'hF,0,0,32'h0F0F0F0F,0), "post_rst");
    last_rd = 32'h0F0F0F0F;

`ifdef MEM_MISALIGN_TRAP_EN
    run_op(mk(1,1,0,3'd2,32'h101,0,32'h55667788,0,0,0,0,0,0,last_rd,1), "mis_lw");
`else
    run_op(mk(1,1,0,3'd2,32'h101,0,32'h55667788,0,2,32'h100,4'hF,0,0,32'h55667788,0), "mis_lw");
    last_rd = 32'h55667788;
`endif

    for (int i = 0; i < 40; i++) begin
      v.valid = ($urandom_range(0, 3) != 0);
      v.rd    = 1'($urandom_range(0, 1));
      v.wr    = 1'($urandom_range(0, 1));
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom % 32'h10000;
      v.wdata = $urandom;
      v.raw   = $urandom;
      v.dly   = $urandom_range(0, 3);
      acc       = v.valid && (v.rd || v.wr);
      v.exp_mis = acc && ref_mis(v.f3, v.addr);
      v.exp_stall = (acc && !v.exp_mis) ? v.dly + 2 : 0;
      v.exp_addr  = v.addr - (v.addr % 4);
      v.exp_be    = ref_be(v.f3, v.addr);
      v.exp_we    = v.wr;
      v.exp_wdata = v.wr ? ref_wdata(v.f3, v.wdata) : 32'h0;
      if (v.exp_stall != 0 && !v.wr) last_rd = ref_load(v.f3, v.addr, v.raw);
      v.exp_rdata = last_rd;
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
